// File: rtl/rx_stat_pkg.sv
// ============================================================================
// Module      : rx_stat_pkg
// Description : Shared constants for the rx statistics scheduler: default
//               event count and counter width, event index map and FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_stat_pkg;

    // Default geometry of the statistics block
    localparam int NUM_EV_DEF = 8;
    localparam int CNT_W_DEF  = 32;

    // Event index map (bit position in stat_vec / counter index)
    localparam int EV_64       = 0;
    localparam int EV_65_127   = 1;
    localparam int EV_128_255  = 2;
    localparam int EV_256_511  = 3;
    localparam int EV_512_1023 = 4;
    localparam int EV_1024_MAX = 5;
    localparam int EV_JUMBO    = 6;
    localparam int EV_LEN_ERR  = 7;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_READ   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_stat_rr_arb.sv
// ============================================================================
// Module      : rx_stat_rr_arb
// Description : Combinational round-robin picker. Returns the lowest pending
//               index at or after the rotating pointer, wrapping from
//               NUM_EV-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_stat_rr_arb
    import rx_stat_pkg::*;
#(
    parameter int NUM_EV = NUM_EV_DEF,
    parameter int IDX_W  = $clog2(NUM_EV)
) (
    input  logic [NUM_EV-1:0] i_pend,
    input  logic [IDX_W-1:0]  i_rr_ptr,
    output logic              o_gnt_valid,
    output logic [IDX_W-1:0]  o_gnt_idx
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap
    localparam int c_SUM_W = IDX_W + 1;

    logic [c_SUM_W-1:0] w_pos;

    // Walk the pending vector starting at the pointer; first hit wins
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_pos       = '0;
        for (int k = 0; k < NUM_EV; k++) begin
            w_pos = {1'b0, i_rr_ptr} + c_SUM_W'(k);
            if (w_pos >= c_SUM_W'(NUM_EV)) begin
                w_pos = w_pos - c_SUM_W'(NUM_EV);
            end
            if (!o_gnt_valid && i_pend[w_pos[IDX_W-1:0]]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rx_stat_scheduler.sv
// ============================================================================
// Module      : rx_stat_scheduler
// Description : Shares one saturating increment path and a counter file
//               among the rx statistic pulses. Pulses become pending bits,
//               are granted round-robin, and host reads are interleaved with
//               priority over updates.
// Options     : RX_STAT_CLR_ON_READ_EN - when defined, a host read clears
//               the counter it returns (clear-on-read); otherwise reads are
//               non-destructive.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_stat_scheduler
    import rx_stat_pkg::*;
#(
    parameter int NUM_EV = NUM_EV_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              rxclk,
    input  logic              reset,
    input  logic [NUM_EV-1:0] stat_vec,
    input  logic              host_rd_req,
    input  logic [2:0]        host_rd_addr,
    output logic              host_rd_ack,
    output logic [CNT_W-1:0]  host_rd_data,
    output logic              drop_err
);

    localparam int               c_IDX_W   = $clog2(NUM_EV);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0]   r_cnt [NUM_EV];
    logic [NUM_EV-1:0]  r_pend;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_gnt;
    state_t             r_state;
    logic               r_ack;
    logic [CNT_W-1:0]   r_rd_data;
    logic               r_drop_err;

    logic               w_gnt_valid;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic               w_take;
    logic [NUM_EV-1:0]  w_clr_mask;
    logic               w_addr_ok;
    logic [c_IDX_W-1:0] w_rd_idx;

    rx_stat_rr_arb #(
        .NUM_EV (NUM_EV),
        .IDX_W  (c_IDX_W)
    ) u_arb (
        .i_pend      (r_pend),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // A grant is taken only from IDLE when the host is not asking to read
    assign w_take     = (r_state == ST_IDLE) && !host_rd_req && w_gnt_valid;
    assign w_clr_mask = w_take ? (NUM_EV'(1) << w_gnt_idx) : '0;
    assign w_addr_ok  = (int'(host_rd_addr) < NUM_EV);
    assign w_rd_idx   = c_IDX_W'(host_rd_addr);

    assign host_rd_ack  = r_ack;
    assign host_rd_data = r_rd_data;
    assign drop_err     = r_drop_err;

    // Pending bits: set by pulses, cleared by grant; a pulse landing on a
    // still-pending, ungranted event is lost and flagged stickily
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | stat_vec;
            if (|(stat_vec & r_pend & ~w_clr_mask)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Scheduler FSM: host read first, otherwise grant the next pending event
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_ack     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (host_rd_req) begin
                        r_state <= ST_READ;
                    end else if (w_gnt_valid) begin
                        r_gnt    <= w_gnt_idx;
                        r_rr_ptr <= (w_gnt_idx == c_IDX_W'(NUM_EV - 1)) ?
                                    '0 : w_gnt_idx + c_IDX_W'(1);
                        r_state  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                end
                ST_READ: begin
                    r_rd_data <= w_addr_ok ? r_cnt[w_rd_idx] : '0;
                    r_ack     <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counter file: saturating increment in UPDATE, optional clear in READ
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_EV; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if ((r_state == ST_UPDATE) && (r_cnt[r_gnt] != c_CNT_MAX)) begin
                r_cnt[r_gnt] <= r_cnt[r_gnt] + CNT_W'(1);
            end
`ifdef RX_STAT_CLR_ON_READ_EN
            // UPDATE and READ never coincide, so this clear cannot collide
            if ((r_state == ST_READ) && w_addr_ok) begin
                r_cnt[w_rd_idx] <= '0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rx_stat_scheduler.sv
// ============================================================================
// Module      : tb_rx_stat_scheduler
// Description : Scoreboard bench for rx_stat_scheduler. Reads push expected
//               ranges into a queue; a monitor pops them on every ack.
//               Event counts come from a simple per-index tally model.
//               Honours RX_STAT_CLR_ON_READ_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_stat_scheduler;

    localparam int          NEV  = 8;
    localparam int          CW   = 8;
    localparam int unsigned MAXV = (1 << CW) - 1;

    logic            rxclk        = 1'b0;
    logic            reset        = 1'b1;
    logic [NEV-1:0]  stat_vec     = '0;
    logic            host_rd_req  = 1'b0;
    logic [2:0]      host_rd_addr = '0;
    logic            host_rd_ack;
    logic [CW-1:0]   host_rd_data;
    logic            drop_err;

    rx_stat_scheduler #(
        .NUM_EV (NEV),
        .CNT_W  (CW)
    ) dut (
        .rxclk        (rxclk),
        .reset        (reset),
        .stat_vec     (stat_vec),
        .host_rd_req  (host_rd_req),
        .host_rd_addr (host_rd_addr),
        .host_rd_ack  (host_rd_ack),
        .host_rd_data (host_rd_data),
        .drop_err     (drop_err)
    );

    always #5 rxclk = ~rxclk;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
        int          addr;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    int unsigned model_cnt [NEV];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model: every accepted event adds one, clamped at full scale
    function automatic void model_events(input logic [NEV-1:0] v);
        for (int i = 0; i < NEV; i++) begin
            if (v[i] && model_cnt[i] < MAXV) model_cnt[i]++;
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NEV; i++) model_cnt[i] = 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge rxclk);
    endtask

    task automatic pulse(input logic [NEV-1:0] v);
        @(negedge rxclk);
        stat_vec = v;
        @(negedge rxclk);
        stat_vec = '0;
    endtask

    // Issue one read, queue its expected range, wait (bounded) for the ack
    task automatic host_read(input int a, input int unsigned lo, input int unsigned hi,
                             input int max_wait);
        exp_t e;
        int   waited;
        bit   got;
        @(negedge rxclk);
        host_rd_addr = 3'(a);
        host_rd_req  = 1'b1;
        e.lo = lo; e.hi = hi; e.addr = a;
        sb_q.push_back(e);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < max_wait) begin
            @(negedge rxclk);
            waited++;
            if (host_rd_ack) got = 1'b1;
        end
        host_rd_req = 1'b0;
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL ack_latency addr %0d: no ack within %0d cycles", a, max_wait);
            void'(sb_q.pop_back());
        end
    endtask

    task automatic read_model(input int a, input int max_wait);
        host_read(a, model_cnt[a], model_cnt[a], max_wait);
`ifdef RX_STAT_CLR_ON_READ_EN
        model_cnt[a] = 0;
`endif
    endtask

    task automatic read_all();
        for (int a = 0; a < NEV; a++) read_model(a, 4);
    endtask

    // Monitor: every ack must match the oldest outstanding expectation
    always @(negedge rxclk) begin
        if (!reset && host_rd_ack) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: data %0h with no read outstanding", host_rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                if ($isunknown(host_rd_data) || 32'(host_rd_data) < mon_e.lo ||
                    32'(host_rd_data) > mon_e.hi) begin
                    n_err++;
                    $display("FAIL rd_data addr %0d: got %0d expected %0d..%0d",
                             mon_e.addr, host_rd_data, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned m5;
        logic [NEV-1:0] v;
        model_clear();

        // Reset state
        idle(3);
        check("rst_ack",  32'(host_rd_ack),  32'd0);
        check("rst_data", 32'(host_rd_data), 32'd0);
        check("rst_drop", 32'(drop_err),     32'd0);
        @(negedge rxclk);
        reset = 1'b0;
        read_all();

        // Single event, read back right behind it
        pulse(8'h01);
        model_events(8'h01);
        read_model(0, 4);

        // All events at once: each counted once, nothing dropped
        pulse(8'hFF);
        model_events(8'hFF);
        idle(20);
        check("drop_after_ff", 32'(drop_err), 32'd0);
        read_all();

        // Re-pulse on the grant cycle is a new event, not a drop
        @(negedge rxclk); stat_vec = 8'h08;
        @(negedge rxclk); stat_vec = 8'h08;
        @(negedge rxclk); stat_vec = '0;
        model_events(8'h08);
        model_events(8'h08);
        idle(8);
        check("drop_grant_cycle", 32'(drop_err), 32'd0);
        read_model(3, 4);

        // Pointer now sits past 3, so index 0 wins the wrap and 3's repeat is lost
        @(negedge rxclk); stat_vec = 8'h0F;
        @(negedge rxclk); stat_vec = 8'h08;
        @(negedge rxclk); stat_vec = '0;
        model_events(8'h0F);
        idle(12);
        check("drop_set", 32'(drop_err), 32'd1);
        read_all();

        // Random isolated bursts, fully drained before any read
        repeat (30) begin
            v = NEV'($urandom);
            pulse(v);
            model_events(v);
            idle(18);
            if ($urandom_range(0, 1) == 1) read_model(int'($urandom_range(0, NEV - 1)), 4);
        end
        read_all();
        check("drop_sticky", 32'(drop_err), 32'd1);

        // Saturation on index 2
        repeat (MAXV + 20) begin
            pulse(8'h04);
            model_events(8'h04);
        end
        idle(6);
        read_model(2, 4);
        read_model(2, 4);

        // Back-to-back reads of one counter (clear-on-read visible here)
        pulse(8'h02);
        model_events(8'h02);
        idle(6);
        read_model(1, 4);
        read_model(1, 4);

        // Host read under continuous traffic on index 5
        m5 = model_cnt[5];
        fork
            begin
                @(negedge rxclk);
                stat_vec = 8'h20;
                idle(40);
                stat_vec = '0;
            end
            begin
                idle(10);
                read_model(0, 4);
            end
        join
        idle(20);
        host_read(5, (m5 + 15 > MAXV) ? MAXV : m5 + 15,
                     (m5 + 41 > MAXV) ? MAXV : m5 + 41, 4);

        // Reset in the middle of pending updates and an in-flight read
        @(negedge rxclk); stat_vec = 8'hFF;
        @(negedge rxclk); stat_vec = '0; host_rd_addr = 3'd0; host_rd_req = 1'b1;
        @(negedge rxclk); reset = 1'b1; host_rd_req = 1'b0;
        sb_q.delete();
        idle(2);
        check("midrst_ack",  32'(host_rd_ack), 32'd0);
        check("midrst_drop", 32'(drop_err),    32'd0);
        @(negedge rxclk);
        reset = 1'b0;
        model_clear();
        idle(20);
        check("post_rst_drop", 32'(drop_err), 32'd0);
        read_all();

        idle(4);
        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
